match_count_display: RTL
========================

// Module: match_count_display
// PURPOSE
//  Downstream stage of the 011 pattern detector: counts detections and shows the
//  total on the 4-digit multiplexed 7-segment display. Runs on the buffered 100 MHz
//  system clock. det is the detector output y, synchronised here. Each rising edge
//  of det adds one to a 4-digit BCD count, which is scanned out to the display.
// PARAMETERS
//  REFRESH_BITS  17  width of scan counter; top 2 bits select digit (~763 Hz/digit @100MHz)
//  WRAP          1   1: 9999 -> 0000 on increment; 0: saturate at 9999
//  BLANK_LZ      1   1: blank leading zeros (digit 0 never blanked); 0: show all digits
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  det        in   1   detector output (level); may be asynchronous to clk
//  clear      in   1   synchronous clear of count and overflow, active-high
//  count_bcd  out  16  {d3,d2,d1,d0} BCD count, d0 = units
//  overflow   out  1   sticky: set when an increment occurs at 9999
//  an         out  4   digit anodes, active-low, an[0] = units digit
//  seg        out  7   {g,f,e,d,c,b,a}, active-low
//  dp         out  1   decimal point, active-low
// BEHAVIOUR
//  - Reset (sync, dominates all): count_bcd=0, overflow=0, sync/edge flops=0,
//    scan counter=0, an=4'b1111, seg=7'h7F, dp=1.
//  - Synchroniser: det -> s0 -> s1 (2 FFs); prev <= s1. inc = s1 & ~prev.
//    If edge k is the first edge sampling det=1, count_bcd updates at edge k+2.
//    One increment per det rising edge, however long det stays high.
//    A det pulse must be high for at least 2 clk cycles to be counted.
//  - Increment: BCD ripple. d0 9->0 carries into d1, and so on.
//    At 9999: WRAP=1 -> 0000 and overflow<=1; WRAP=0 -> hold 9999 and overflow<=1.
//  - clear=1: count_bcd<=0 and overflow<=0 at the next edge. Clear wins over a
//    simultaneous inc; that edge is lost, not deferred. Synchroniser is not cleared.
//  - Scan: free-running REFRESH_BITS counter, wraps to 0. sel = counter[MSB:MSB-1].
//    an, seg, dp registered from sel and count: one-cycle latency after the counter.
//    an = ~(4'b0001 << sel).
//  - Blanking (BLANK_LZ=1): digit i>0 blanked (seg=7'h7F) when d3..di are all 0.
//    Count 0 shows "   0"; count 40 shows "  40".
//  - Encoding (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000
//    4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//    Non-BCD digits are not reachable; they decode to 7'h7F.
//  - dp=0 only when sel=3 and overflow=1; otherwise dp=1.
//  - Reset mid-scan or mid-count: everything returns to reset values at the next
//    edge. A det held high through reset is not counted after reset deasserts;
//    prev tracks s1 first.
// TESTING (bench uses REFRESH_BITS=4 for fast scans)
//  1 reset, det=0 -> an=1111, seg=7F, dp=1, count_bcd=0000; after release an
//    cycles 1110,1101,1011,0111, each digit held 4 clks.
//  2 det high 10 clks -> count_bcd=0001 exactly 2 edges after det first sampled
//    high; no further increments while det stays high.
//  3 9 det pulses (3 high/3 low) -> 0009; one more -> 0010; during the units
//    slot seg=1000000, tens slot 1111001, hundreds/thousands slots 7F.
//  4 preload 9999 via pulses, WRAP=1, one pulse -> 0000, overflow=1, dp=0 in the
//    digit-3 slot; repeat with WRAP=0 -> holds 9999, overflow=1.
//  5 clear and inc in the same cycle at count 0005 -> 0000, overflow=0; the next
//    det edge -> 0001.
//  6 reset asserted while det high and count=0042 -> 0000; det still high after
//    release -> stays 0000 until det falls and rises again.

Source files
------------

// File: rtl/match_count_display.sv
`default_nettype none
// ============================================================================
//  Module      : match_count_display
//  Description : Counts rising edges of the (asynchronous) pattern-detector
//                output in a 4-digit BCD counter and scans the total out to a
//                4-digit multiplexed, active-low 7-segment display.
//  Revision    : 1.0  initial release
// ============================================================================
module match_count_display #(
    parameter int REFRESH_BITS = 17,
    parameter bit WRAP         = 1'b1,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        det,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic        overflow,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [6:0]  c_SEG_BLANK = 7'h7F;
    localparam logic [15:0] c_BCD_MAX   = 16'h9999;

    // Synchroniser, edge detector and post-reset qualification
    logic        r_s0;
    logic        r_s1;
    logic        r_prev;
    logic [2:0]  r_qual;
    logic        w_inc;

    // Counting
    logic [15:0] w_next;
    logic        w_carry;

    // Display scan
    logic [REFRESH_BITS-1:0] r_scan;
    logic [1:0]  w_sel;
    logic [3:0]  w_digit;
    logic [3:1]  w_lz;
    logic        w_blank;

    // Decode one BCD digit to active-low gfedcba; anything non-BCD is dark.
    function automatic logic [6:0] f_decode(input logic [3:0] digit);
        logic [6:0] v_seg;
        case (digit)
            4'd0:    v_seg = 7'b1000000;
            4'd1:    v_seg = 7'b1111001;
            4'd2:    v_seg = 7'b0100100;
            4'd3:    v_seg = 7'b0110000;
            4'd4:    v_seg = 7'b0011001;
            4'd5:    v_seg = 7'b0010010;
            4'd6:    v_seg = 7'b0000010;
            4'd7:    v_seg = 7'b1111000;
            4'd8:    v_seg = 7'b0000000;
            4'd9:    v_seg = 7'b0010000;
            default: v_seg = c_SEG_BLANK;
        endcase
        return v_seg;
    endfunction

    // Two-flop synchroniser plus history flop; r_qual fills with ones so that
    // an edge is only accepted once both s1 and prev hold post-reset samples
    // (a det held high through reset is therefore never counted).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0   <= 1'b0;
            r_s1   <= 1'b0;
            r_prev <= 1'b0;
            r_qual <= 3'b000;
        end else begin
            r_s0   <= det;
            r_s1   <= r_s0;
            r_prev <= r_s1;
            r_qual <= {r_qual[1:0], 1'b1};
        end
    end

    assign w_inc = r_s1 & ~r_prev & r_qual[2];

    // BCD ripple increment of the current count.
    always_comb begin
        w_carry = 1'b1;
        w_next  = count_bcd;
        for (int i = 0; i < 4; i++) begin
            if (w_carry) begin
                if (count_bcd[4*i +: 4] == 4'd9) begin
                    w_next[4*i +: 4] = 4'd0;
                end else begin
                    w_next[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
                    w_carry          = 1'b0;
                end
            end
        end
    end

    // Count and sticky overflow; clear beats a coincident increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_bcd <= 16'h0000;
            overflow  <= 1'b0;
        end else if (clear) begin
            count_bcd <= 16'h0000;
            overflow  <= 1'b0;
        end else if (w_inc) begin
            if (count_bcd == c_BCD_MAX) begin
                overflow  <= 1'b1;
                count_bcd <= WRAP ? 16'h0000 : c_BCD_MAX;
            end else begin
                count_bcd <= w_next;
            end
        end
    end

    // Free-running scan counter; its top two bits select the digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= '0;
        end else begin
            r_scan <= r_scan + REFRESH_BITS'(1);
        end
    end

    assign w_sel = r_scan[REFRESH_BITS-1 -: 2];

    // A digit is a leading zero when it and every more significant digit are 0.
    assign w_lz[3] = (count_bcd[15:12] == 4'd0);
    assign w_lz[2] = w_lz[3] & (count_bcd[11:8] == 4'd0);
    assign w_lz[1] = w_lz[2] & (count_bcd[7:4]  == 4'd0);

    // Pick the digit for the active slot and decide whether it is blanked.
    always_comb begin
        w_digit = count_bcd[3:0];
        w_blank = 1'b0;
        case (w_sel)
            2'd1: begin
                w_digit = count_bcd[7:4];
                w_blank = BLANK_LZ & w_lz[1];
            end
            2'd2: begin
                w_digit = count_bcd[11:8];
                w_blank = BLANK_LZ & w_lz[2];
            end
            2'd3: begin
                w_digit = count_bcd[15:12];
                w_blank = BLANK_LZ & w_lz[3];
            end
            default: begin
                w_digit = count_bcd[3:0];
                w_blank = 1'b0;
            end
        endcase
    end

    // Registered display drive; dp marks overflow in the thousands slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= 4'b1111;
            seg <= c_SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << w_sel);
            seg <= w_blank ? c_SEG_BLANK : f_decode(w_digit);
            dp  <= ~((w_sel == 2'd3) & overflow);
        end
    end

endmodule
`default_nettype wire
